// File: rtl/fft64_pkg.sv
// Shared definitions for the 64-point FFT stage sequencers.
// Holds the sequencer state encoding and the datapath geometry constants
// (8 lanes per word, 8 words per frame, 3-bit beat counter, 10-bit samples,
// 8-bit frame counter).
package fft64_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_e;

    localparam int LANES = 8;
    localparam int CNT_W = 3;
    localparam int DW    = 10;
    localparam int FRM_W = 8;

endpackage

// File: rtl/fft64_beat_cnt.sv
// Beat counter shared by the FFT stage sequencers.
// Counts 0..LANES-1 while enabled and wraps back to 0; clear has priority
// over enable. term flags the last beat of a phase.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   clr    in   force the count to 0 on the next edge
//   en     in   advance the count on the next edge
//   cnt    out  current beat (CNT_W bits)
//   term   out  current beat is LANES-1
module fft64_beat_cnt
    import fft64_pkg::*;
#(
    parameter int LANES = fft64_pkg::LANES,
    parameter int CNT_W = fft64_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign term = (cnt_q == CNT_W'(LANES - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // Explicit wrap so a non-power-of-two LANES still ends each phase.
            cnt_d = term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft64_cb_seq.sv
// Sequencer for the 8x8 corner-turn buffer of the 64-point FFT.
// Waits for a start-of-frame word, pulses the buffer start, paces upstream
// through the 8-beat load phase, then tags the 8-beat send phase with
// framing, bad-frame marking and twiddle column addresses.
//
// Optional build macro FFT64_CB_SEQ_CHECK_EN: when defined, the buffer's
// status (cb_start_send, cb_counter) is compared against the sequencer's own
// phase and beat every cycle and any disagreement sets err_sync. When not
// defined, err_sync is tied low and the status inputs are ignored.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   in_valid/in_sof  upstream word valid and first-word marker
//   in_ready         upstream word consumed this cycle
//   cb_start_count   one-cycle start pulse to the buffer
//   cb_start_send    buffer send-phase status
//   cb_counter       buffer beat counter
//   out_valid        output word valid (send phase)
//   out_sof/out_eof  first / last output word of a frame
//   out_bad          output frame was loaded with an underrun
//   tw_addr          twiddle ROM column for the current output word
//   frame_cnt        completed output frames (wraps)
//   err_underrun     sticky underrun flag
//   err_sync         sticky buffer-desync flag
module fft64_cb_seq
    import fft64_pkg::*;
#(
    parameter int LANES = fft64_pkg::LANES,
    parameter int CNT_W = fft64_pkg::CNT_W,
    parameter int FRM_W = fft64_pkg::FRM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic             cb_start_count,
    input  logic             cb_start_send,
    input  logic [CNT_W-1:0] cb_counter,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_bad,
    output logic [CNT_W-1:0] tw_addr,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             err_underrun,
    output logic             err_sync
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] beat;
    logic             beat_term;
    logic             beat_en;
    logic             beat_clr;

    logic             bad_q;
    logic             bad_d;
    logic             err_underrun_q;
    logic             err_underrun_d;
    logic [FRM_W-1:0] frame_cnt_q;
    logic [FRM_W-1:0] frame_cnt_d;

    // The counter only runs inside LOAD and SEND; it is held at 0 otherwise
    // so each phase starts on beat 0.
    assign beat_en  = (state_q == LOAD) || (state_q == SEND);
    assign beat_clr = !beat_en;

    fft64_beat_cnt #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (beat_clr),
        .en    (beat_en),
        .cnt   (beat),
        .term  (beat_term)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (in_valid && in_sof) state_d = START;
            START: state_d = LOAD;
            LOAD:  if (beat_term) state_d = SEND;
            SEND:  if (beat_term) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready       = 1'b0;
        cb_start_count = 1'b0;
        out_valid      = 1'b0;
        out_sof        = 1'b0;
        out_eof        = 1'b0;
        out_bad        = 1'b0;
        tw_addr        = '0;
        unique case (state_q)
            // Non-sof words are swallowed so the controller resynchronises;
            // the sof word itself is held until LOAD beat 0.
            IDLE:  in_ready = in_valid && !in_sof;
            START: cb_start_count = 1'b1;
            LOAD:  in_ready = 1'b1;
            SEND: begin
                out_valid = 1'b1;
                out_sof   = (beat == '0);
                out_eof   = beat_term;
                out_bad   = bad_q;
                tw_addr   = beat;
            end
            default: ;
        endcase
    end

    // Frame status: the buffer cannot stall, so a missing word only marks the
    // frame bad and the load phase still runs its full length.
    always_comb begin
        bad_d          = bad_q;
        err_underrun_d = err_underrun_q;
        frame_cnt_d    = frame_cnt_q;
        if ((state_q == LOAD) && !in_valid) begin
            bad_d          = 1'b1;
            err_underrun_d = 1'b1;
        end
        if ((state_q == SEND) && beat_term) begin
            bad_d       = 1'b0;
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bad_q          <= 1'b0;
            err_underrun_q <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            bad_q          <= bad_d;
            err_underrun_q <= err_underrun_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign err_underrun = err_underrun_q;
    assign frame_cnt    = frame_cnt_q;

`ifdef FFT64_CB_SEQ_CHECK_EN
    logic sync_bad;
    logic err_sync_q;
    logic err_sync_d;

    // The buffer's send flag and beat must track our own phase and beat.
    always_comb begin
        sync_bad = 1'b0;
        unique case (state_q)
            LOAD:    sync_bad = (cb_counter != beat) || cb_start_send;
            SEND:    sync_bad = (cb_counter != beat) || !cb_start_send;
            default: sync_bad = cb_start_send;
        endcase
        err_sync_d = err_sync_q || sync_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sync_q <= 1'b0;
        end else begin
            err_sync_q <= err_sync_d;
        end
    end

    assign err_sync = err_sync_q;
`else
    logic unused_cb_status;
    assign unused_cb_status = cb_start_send ^ (^cb_counter);
    assign err_sync         = 1'b0;
`endif

endmodule
